// File: rtl/flag_branch_unit_pkg.sv
// Purpose: shared constants for the flag/branch unit (op classes, condition codes, flag bits, FSM states).
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package flag_branch_unit_pkg;

    // EX op classes: which flags the instruction writes
    localparam logic [1:0] OPC_NONE  = 2'b00;
    localparam logic [1:0] OPC_ARITH = 2'b01;   // writes Z, V, N
    localparam logic [1:0] OPC_LOGIC = 2'b10;   // writes Z only
    localparam logic [1:0] OPC_RSVD  = 2'b11;

    // Branch condition codes
    localparam logic [2:0] CC_NE     = 3'b000;
    localparam logic [2:0] CC_EQ     = 3'b001;
    localparam logic [2:0] CC_GT     = 3'b010;
    localparam logic [2:0] CC_LT     = 3'b011;
    localparam logic [2:0] CC_GTE    = 3'b100;
    localparam logic [2:0] CC_LTE    = 3'b101;
    localparam logic [2:0] CC_OVFL   = 3'b110;
    localparam logic [2:0] CC_UNCOND = 3'b111;

    // Bit positions inside the {Z,V,N} flag vector
    localparam int FLAG_Z = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_N = 0;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } fbu_state_t;

    function automatic logic opc_writes_flags(input logic [1:0] opc);
        return (opc == OPC_ARITH) || (opc == OPC_LOGIC);
    endfunction

endpackage

// File: rtl/flag_branch_unit_branch_cond_eval.sv
// Purpose: evaluate a 3-bit branch condition code against a {Z,V,N} flag set.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
// Ports: ccc (condition code), zvn ({Z,V,N} flags), taken (condition holds).
module branch_cond_eval
    import flag_branch_unit_pkg::*;
(
    input  logic [2:0] ccc,
    input  logic [2:0] zvn,
    output logic       taken
);

    logic z;
    logic v;
    logic n;

    assign z = zvn[FLAG_Z];
    assign v = zvn[FLAG_V];
    assign n = zvn[FLAG_N];

    always_comb begin
        taken = 1'b0;
        case (ccc)
            CC_NE:     taken = ~z;
            CC_EQ:     taken = z;
            CC_GT:     taken = ~z & ~n;
            CC_LT:     taken = n;
            CC_GTE:    taken = z | (~z & ~n);
            CC_LTE:    taken = n | z;
            CC_OVFL:   taken = v;
            CC_UNCOND: taken = 1'b1;
            default:   taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/flag_branch_unit.sv
// Purpose: Z/V/N flag register fed from EX, and conditional branch resolution in ID.
// Latency: flags visible 1 cycle after EX result; br_taken combinational (bypass) or after a 1-cycle stall on flag hazard.
// Backpressure: stall freezes flag writes and FSM; br_stall asks IF/ID to hold one cycle (BYPASS=0 only).
// Ports: clk/rst_n; ex_valid, ex_op_class, ex_result, ex_ovfl from EX; stall, flush pipeline controls;
//        br_valid, br_ccc from ID; br_taken, br_stall, flags ({Z,V,N}) outputs.
module flag_branch_unit
    import flag_branch_unit_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter bit BYPASS = 1'b0
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ex_valid,
    input  logic [1:0]       ex_op_class,
    input  logic [WIDTH-1:0] ex_result,
    input  logic             ex_ovfl,
    input  logic             stall,
    input  logic             flush,
    input  logic             br_valid,
    input  logic [2:0]       br_ccc,
    output logic             br_taken,
    output logic             br_stall,
    output logic [2:0]       flags
);

    logic       opc_wr;
    logic       flag_we;
    logic       haz;
    logic [2:0] flags_q;
    logic [2:0] flags_next;
    logic [2:0] eval_flags;
    logic       cond_true;
    fbu_state_t state_q;

    assign opc_wr  = opc_writes_flags(ex_op_class);
    assign flag_we = ex_valid & ~flush & ~stall & opc_wr;
    // The hazard ignores stall: a frozen pipeline still has the producer in EX.
    assign haz     = br_valid & ex_valid & ~flush & opc_wr;

    // Logic/shift ops only touch Z; V and N carry over from the register.
    always_comb begin
        flags_next         = flags_q;
        flags_next[FLAG_Z] = (ex_result == '0);
        if (ex_op_class == OPC_ARITH) begin
            flags_next[FLAG_V] = ex_ovfl;
            flags_next[FLAG_N] = ex_result[WIDTH-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q <= 3'b000;
        end else if (flag_we) begin
            flags_q <= flags_next;
        end
    end

    // Only the bypass build forwards the in-flight flags; the stalling build
    // always evaluates against the register (after the stall it is current).
    assign eval_flags = (BYPASS && haz) ? flags_next : flags_q;

    branch_cond_eval u_cond (
        .ccc   (br_ccc),
        .zvn   (eval_flags),
        .taken (cond_true)
    );

    // IDLE -> WAIT on an unstalled hazard; WAIT leaves on flush or when stall drops.
    // In the bypass build the hazard never starts a wait, so the FSM sits in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else if (state_q == ST_IDLE) begin
            if (!BYPASS && haz && !stall) begin
                state_q <= ST_WAIT;
            end
        end else begin
            if (flush || !stall) begin
                state_q <= ST_IDLE;
            end
        end
    end

    always_comb begin
        br_stall = 1'b0;
        br_taken = 1'b0;
        if (!BYPASS && (state_q == ST_IDLE) && haz && !stall) begin
            br_stall = 1'b1;
        end else if ((state_q == ST_WAIT) && flush) begin
            br_taken = 1'b0;
        end else begin
            br_taken = br_valid & cond_true;
        end
    end

    assign flags = flags_q;

endmodule
